// File: rtl/lsu_pkg.sv
// Shared types, funct3 codes and request legality helpers for the load/store unit.
package lsu_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned F3_WIDTH = 3;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    STORE_RD,
    STORE_WR,
    RESP
  } lsu_state_e;

  localparam logic [F3_WIDTH-1:0] F3_B  = 3'b000;
  localparam logic [F3_WIDTH-1:0] F3_H  = 3'b001;
  localparam logic [F3_WIDTH-1:0] F3_W  = 3'b010;
  localparam logic [F3_WIDTH-1:0] F3_BU = 3'b100;
  localparam logic [F3_WIDTH-1:0] F3_HU = 3'b101;

  // Request fields held for the duration of one access.
  typedef struct packed {
    logic                we;
    logic [F3_WIDTH-1:0] funct3;
    logic [XLEN-1:0]     wdata;
  } lsu_req_t;

  function automatic logic is_legal(input logic we, input logic [F3_WIDTH-1:0] funct3);
    if (we) return funct3 inside {F3_B, F3_H, F3_W};
    return funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
  endfunction

  function automatic logic is_misaligned(input logic [F3_WIDTH-1:0] funct3,
                                         input logic [1:0]          addr_lo);
    case (funct3)
      F3_H, F3_HU: return addr_lo[0];
      F3_W:        return addr_lo != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian lane handling: load extract/extend and sub-word store merge.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [XLEN-1:0]     i_word,
  input  logic [1:0]          i_addr_lo,
  input  logic [F3_WIDTH-1:0] i_funct3,
  input  logic [XLEN-1:0]     i_wdata,
  output logic [XLEN-1:0]     o_load_data_c,
  output logic [XLEN-1:0]     o_store_word_c
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Load path: pick the lane, then sign- or zero-extend.
  always_comb begin
    w_byte        = i_word[7:0];
    w_half        = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];
    o_load_data_c = i_word;
    case (i_addr_lo)
      2'd0:    w_byte = i_word[7:0];
      2'd1:    w_byte = i_word[15:8];
      2'd2:    w_byte = i_word[23:16];
      default: w_byte = i_word[31:24];
    endcase
    case (i_funct3)
      F3_B:    o_load_data_c = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_load_data_c = {24'h000000, w_byte};
      F3_H:    o_load_data_c = {{16{w_half[15]}}, w_half};
      F3_HU:   o_load_data_c = {16'h0000, w_half};
      default: o_load_data_c = i_word;
    endcase
  end

  // Store path: replace only the addressed lane of the word read back.
  always_comb begin
    o_store_word_c = i_word;
    case (i_funct3)
      F3_B: begin
        case (i_addr_lo)
          2'd0:    o_store_word_c[7:0]   = i_wdata[7:0];
          2'd1:    o_store_word_c[15:8]  = i_wdata[7:0];
          2'd2:    o_store_word_c[23:16] = i_wdata[7:0];
          default: o_store_word_c[31:24] = i_wdata[7:0];
        endcase
      end
      F3_H: begin
        if (i_addr_lo[1]) o_store_word_c[31:16] = i_wdata[15:0];
        else              o_store_word_c[15:0]  = i_wdata[15:0];
      end
      default: o_store_word_c = i_wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit in front of a word-wide data memory without byte enables;
// sub-word stores are performed as read-modify-write.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = 32
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [2:0]               req_funct3,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  output logic                     resp_valid,
  output logic [DATA_WIDTH-1:0]    resp_rdata,
  output logic                     resp_err,
  output logic [ADDRESS_WIDTH-1:0] mem_A,
  output logic [DATA_WIDTH-1:0]    mem_WD,
  output logic                     mem_WE,
  input  logic [DATA_WIDTH-1:0]    mem_RD
);

  lsu_state_e               r_state;
  lsu_state_e               w_state_nxt;
  lsu_req_t                 r_req;
  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic                     r_req_ready;
  logic                     r_resp_valid;
  logic                     r_resp_err;
  logic [DATA_WIDTH-1:0]    r_resp_rdata;
  logic [DATA_WIDTH-1:0]    r_mem_wd;

  logic                     w_accept;
  logic                     w_req_err;
  logic                     w_resp_err_nxt;
  logic [DATA_WIDTH-1:0]    w_resp_rdata_nxt;
  logic [DATA_WIDTH-1:0]    w_load_data;
  logic [DATA_WIDTH-1:0]    w_store_word;

  lsu_lane_align u_lane_align (
    .i_word         (mem_RD),
    .i_addr_lo      (r_addr[1:0]),
    .i_funct3       (r_req.funct3),
    .i_wdata        (r_req.wdata),
    .o_load_data_c  (w_load_data),
    .o_store_word_c (w_store_word)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state, write strobe and the response value captured on entry to RESP.
  always_comb begin
    w_state_nxt      = r_state;
    w_accept         = req_valid && r_req_ready;
    w_req_err        = !is_legal(req_we, req_funct3) ||
                       is_misaligned(req_funct3, req_addr[1:0]);
    w_resp_rdata_nxt = '0;
    w_resp_err_nxt   = 1'b0;
    mem_WE           = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_req_err) begin
            w_state_nxt    = RESP;
            w_resp_err_nxt = 1'b1;
          end else if (!req_we) begin
            w_state_nxt = LOAD;
          end else if (req_funct3 == F3_W) begin
            w_state_nxt = STORE_WR;
          end else begin
            w_state_nxt = STORE_RD;
          end
        end
      end
      LOAD: begin
        w_state_nxt = RESP;
        if (!r_req.we) w_resp_rdata_nxt = w_load_data;
      end
      STORE_RD: w_state_nxt = STORE_WR;
      STORE_WR: begin
        mem_WE      = 1'b1;
        w_state_nxt = RESP;
      end
      RESP:     w_state_nxt = IDLE;
      default:  w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_req        <= '0;
      r_addr       <= '0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
      r_mem_wd     <= '0;
    end else begin
      r_req_ready  <= (w_state_nxt == IDLE);
      r_resp_valid <= (w_state_nxt == RESP);
      if (w_accept) begin
        r_addr       <= req_addr;
        r_req.we     <= req_we;
        r_req.funct3 <= req_funct3;
        r_req.wdata  <= req_wdata;
      end
      // Full-word stores bypass the read; sub-word stores use the merged word.
      if (w_state_nxt == STORE_WR) begin
        r_mem_wd <= (r_state == STORE_RD) ? w_store_word : req_wdata;
      end
      if (w_state_nxt == RESP) begin
        r_resp_rdata <= w_resp_rdata_nxt;
        r_resp_err   <= w_resp_err_nxt;
      end
    end
  end

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;
  assign mem_A      = {r_addr[ADDRESS_WIDTH-1:2], 2'b00};
  assign mem_WD     = r_mem_wd;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a behavioural word memory.
module tb_load_store_unit;

  logic        CLK = 1'b0;
  logic        RST;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_A;
  logic [31:0] mem_WD;
  logic        mem_WE;
  logic [31:0] mem_RD;

  load_store_unit #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_A      (mem_A),
    .mem_WD     (mem_WD),
    .mem_WE     (mem_WE),
    .mem_RD     (mem_RD)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Behavioural data memory plus a backdoor port for preloading.
  logic [31:0] mem [0:1023];
  logic [31:0] ref_mem [0:1023];
  logic        bd_we = 1'b0;
  logic [9:0]  bd_idx = '0;
  logic [31:0] bd_data = '0;

  assign mem_RD = mem[mem_A[11:2]];

  always @(posedge CLK) begin
    if (mem_WE)     mem[mem_A[11:2]] <= mem_WD;
    else if (bd_we) mem[bd_idx]      <= bd_data;
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
    int          lat;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  exp_t exp_q[$];
  wr_t  wr_q[$];
  exp_t mon_e;
  wr_t  mon_w;
  int   n_checks = 0;
  int   n_errors = 0;
  int   last_resp_cyc = -10;
  bit   prev_held = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_load(input logic [31:0] word, input logic [1:0] lo,
                                         input logic [2:0] f3);
    logic [31:0] s;
    s = word >> (int'(lo) * 8);
    case (f3)
      3'b000:  return {{24{s[7]}}, s[7:0]};
      3'b100:  return {24'h0, s[7:0]};
      3'b001:  return {{16{s[15]}}, s[15:0]};
      3'b101:  return {16'h0, s[15:0]};
      default: return word;
    endcase
  endfunction

  function automatic logic [31:0] m_store(input logic [31:0] word, input logic [1:0] lo,
                                          input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] mask;
    mask = (f3 == 3'b000) ? 32'h0000_00FF : (f3 == 3'b001) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    mask = mask << (int'(lo) * 8);
    return (word & ~mask) | ((wd << (int'(lo) * 8)) & mask);
  endfunction

  function automatic bit m_err(input bit we, input logic [2:0] f3, input logic [1:0] lo);
    bit legal;
    bit mis;
    legal = we ? (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010)
               : (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010 || f3 == 3'b100 || f3 == 3'b101);
    mis   = ((f3 == 3'b001 || f3 == 3'b101) && lo[0]) || (f3 == 3'b010 && lo != 2'b00);
    return !legal || mis;
  endfunction

  // Response and write-port monitor.
  always @(negedge CLK) begin
    if (!RST) begin
      if (resp_valid) begin
        last_resp_cyc = cyc;
        if (exp_q.size() == 0) begin
          check("resp_unexpected", 32'(resp_valid), 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("resp_rdata", resp_rdata, mon_e.rdata);
          check("resp_err", 32'(resp_err), 32'(mon_e.err));
          check("resp_latency", 32'(cyc - mon_e.acc), 32'(mon_e.lat));
        end
      end
      if (mem_WE) begin
        if (wr_q.size() == 0) begin
          check("mem_we_unexpected", 32'(mem_WE), 32'd0);
        end else begin
          mon_w = wr_q.pop_front();
          check("mem_A", mem_A, mon_w.addr);
          check("mem_WD", mem_WD, mon_w.data);
        end
      end
    end
  end

  task automatic bd_write(input logic [31:0] addr, input logic [31:0] data);
    bd_we   = 1'b1;
    bd_idx  = addr[11:2];
    bd_data = data;
    ref_mem[addr[11:2]] = data;
    @(negedge CLK);
    bd_we = 1'b0;
  endtask

  // Drive one request at a negedge; expectations come from the reference model.
  task automatic issue(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input bit hold);
    int   n;
    exp_t e;
    wr_t  w;
    logic [9:0] idx;
    logic [1:0] lo;
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (!req_ready) begin
      check("ready_timeout", 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      prev_held = 1'b0;
      return;
    end
    if (prev_held) check("b2b_accept_cycle", 32'(cyc), 32'(last_resp_cyc + 1));
    idx     = addr[11:2];
    lo      = addr[1:0];
    e.acc   = cyc;
    e.rdata = '0;
    e.err   = m_err(we, f3, lo);
    if (e.err) begin
      e.lat = 1;
    end else if (!we) begin
      e.lat   = 2;
      e.rdata = m_load(ref_mem[idx], lo, f3);
    end else begin
      e.lat  = (f3 == 3'b010) ? 2 : 3;
      w.addr = {addr[31:2], 2'b00};
      w.data = m_store(ref_mem[idx], lo, f3, wd);
      ref_mem[idx] = w.data;
      wr_q.push_back(w);
    end
    exp_q.push_back(e);
    @(negedge CLK);
    check("busy_after_accept", 32'(req_ready), 32'd0);
    if (!hold) req_valid = 1'b0;
    prev_held = hold;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || wr_q.size() != 0) && n < 40) begin
      @(negedge CLK);
      n++;
    end
    check("drain_resp_q", 32'(exp_q.size()), 32'd0);
    check("drain_wr_q", 32'(wr_q.size()), 32'd0);
    @(negedge CLK);
  endtask

  initial begin
    RST        = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = '0;
    req_addr   = '0;
    req_wdata  = '0;
    #1 RST = 1'b1;
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_mem_A", mem_A, 32'd0);
    check("rst_mem_WD", mem_WD, 32'd0);
    check("rst_mem_WE", 32'(mem_WE), 32'd0);

    @(negedge CLK);
    bd_write(32'h100, 32'h8899AABB);
    bd_write(32'h104, 32'h01020304);
    bd_write(32'h200, 32'h11223344);
    bd_write(32'h300, 32'hDEADBEEF);
    RST = 1'b0;
    @(negedge CLK);

    // Loads with every extension mode.
    issue(1'b0, 3'b000, 32'h101, 32'h0, 1'b0);
    issue(1'b0, 3'b100, 32'h101, 32'h0, 1'b0);
    issue(1'b0, 3'b001, 32'h102, 32'h0, 1'b0);
    issue(1'b0, 3'b101, 32'h100, 32'h0, 1'b0);
    issue(1'b0, 3'b010, 32'h100, 32'h0, 1'b0);

    // Sub-word read-modify-write stores.
    issue(1'b1, 3'b000, 32'h203, 32'h000000EE, 1'b0);
    drain();
    bd_write(32'h200, 32'h00000000);
    issue(1'b1, 3'b001, 32'h202, 32'h0000CAFE, 1'b0);
    issue(1'b0, 3'b001, 32'h202, 32'h0, 1'b0);

    // Misaligned and illegal requests.
    issue(1'b0, 3'b010, 32'h106, 32'h0, 1'b0);
    issue(1'b1, 3'b001, 32'h201, 32'h0000BEEF, 1'b0);
    issue(1'b0, 3'b011, 32'h100, 32'h0, 1'b0);
    issue(1'b1, 3'b100, 32'h100, 32'h0000FFFF, 1'b0);
    issue(1'b1, 3'b010, 32'h102, 32'h12345678, 1'b0);

    // Back-to-back with req_valid held.
    issue(1'b1, 3'b010, 32'h104, 32'h55667788, 1'b1);
    issue(1'b0, 3'b010, 32'h104, 32'h0, 1'b1);
    issue(1'b0, 3'b100, 32'h107, 32'h0, 1'b1);
    issue(1'b1, 3'b000, 32'h105, 32'h00000099, 1'b1);
    issue(1'b0, 3'b001, 32'h106, 32'h0, 1'b1);
    issue(1'b0, 3'b111, 32'h104, 32'h0, 1'b1);
    issue(1'b0, 3'b010, 32'h104, 32'h0, 1'b0);
    drain();

    // Reset while the SW write strobe is high.
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 32'h300;
    req_wdata  = 32'h12345678;
    check("abort_ready_pre", 32'(req_ready), 32'd1);
    mon_w.addr = 32'h300;
    mon_w.data = 32'h12345678;
    wr_q.push_back(mon_w);
    @(negedge CLK);
    req_valid = 1'b0;
    check("abort_we_in_store_wr", 32'(mem_WE), 32'd1);
    #2 RST = 1'b1;
    #1;
    check("abort_mem_WE", 32'(mem_WE), 32'd0);
    check("abort_req_ready", 32'(req_ready), 32'd1);
    check("abort_resp_valid", 32'(resp_valid), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    prev_held = 1'b0;
    @(negedge CLK);
    issue(1'b0, 3'b010, 32'h300, 32'h0, 1'b0);
    drain();

    check("mem_0x100", mem[32'h100 >> 2], ref_mem[32'h100 >> 2]);
    check("mem_0x104", mem[32'h104 >> 2], ref_mem[32'h104 >> 2]);
    check("mem_0x200", mem[32'h200 >> 2], ref_mem[32'h200 >> 2]);
    check("mem_0x300", mem[32'h300 >> 2], 32'hDEADBEEF);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at time limit, expected finish");
    $fatal(1);
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the execute stage and data_memory.
- Turns RV32I load/store requests (LB/LH/LW/LBU/LHU/SB/SH/SW) into word-wide data_memory accesses.
- data_memory has no byte enables, so sub-word stores are done as read-modify-write.
- Performs byte-lane extraction and sign/zero extension for loads, and flags misaligned or illegal accesses instead of issuing them.

Parameters:
- ADDRESS_WIDTH, 32, byte-address width of the request and of mem_A.
- DATA_WIDTH, 32, data word width; only 32 is supported.

Ports:
- CLK  input  1  clock, rising-edge.
- RST  input  1  asynchronous active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  unit can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_funct3  input  3  RV32I funct3 size/sign code.
- req_addr  input  ADDRESS_WIDTH  byte address.
- req_wdata  input  DATA_WIDTH  store data, right-aligned.
- resp_valid  output  1  one-cycle completion pulse.
- resp_rdata  output  DATA_WIDTH  extended load result; 0 for stores and errors.
- resp_err  output  1  misaligned or illegal funct3; valid with resp_valid.
- mem_A  output  ADDRESS_WIDTH  word-aligned address to data_memory.
- mem_WD  output  DATA_WIDTH  write data to data_memory.
- mem_WE  output  1  write enable to data_memory.
- mem_RD  input  DATA_WIDTH  combinational read data from data_memory.

Behaviour:
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_A=0, mem_WD=0, mem_WE=0.
- Handshake: accept when req_valid && req_ready.
  - req_ready=1 only in IDLE.
  - On accept, latch addr, funct3, we and wdata.
  - No response backpressure; the consumer must take resp_* in the resp_valid cycle.
- Address output: mem_A = {addr_q[ADDRESS_WIDTH-1:2], 2'b00}.
- Write data: mem_WD is registered.
- Write enable: mem_WE is decoded combinationally from state (asserted only in STORE_WR), so RST drops it immediately.
- Legality check at accept:
  - Loads: funct3 must be 000/001/010/100/101.
  - Stores: funct3 must be 000/001/010.
  - Otherwise illegal.
- Alignment check at accept:
  - Half (funct3 001/101) misaligned if addr[0]=1.
  - Word misaligned if addr[1:0]!=0.
- States:
  - IDLE:
    - error -> RESP with err_q=1.
    - load -> LOAD.
    - SW -> STORE_WR with mem_WD=wdata.
    - SB/SH -> STORE_RD.
  - LOAD: mem_A driven; mem_RD lane-extracted into rdata_q at the cycle end -> RESP.
  - STORE_RD: mem_RD captured, the target lane replaced with wdata into mem_WD -> STORE_WR.
  - STORE_WR: mem_WE=1 for exactly one cycle -> RESP.
  - RESP: resp_valid=1 with resp_rdata/resp_err from registers -> IDLE. resp_rdata and resp_err hold their last values outside RESP.
- Latency, counted from the accept edge to the resp_valid cycle:
  - load: 2 cycles.
  - SW: 2 cycles.
  - SB/SH: 3 cycles.
  - error: 1 cycle.
- Throughput: next accept occurs in the cycle after RESP.
- Lanes are little-endian:
  - Byte lane = addr[1:0], bits [8*lane+7 : 8*lane].
  - Half lane = addr[1], bits [16*addr[1]+15 : 16*addr[1]].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- Errors never assert mem_WE and never change memory; resp_rdata=0.
- Reset mid-operation returns to IDLE. A store interrupted before STORE_WR writes nothing. Asserting RST during STORE_WR aborts the write and deasserts mem_WE immediately.

Decomposition:
- lsu_pkg holds:
  - the state enum (IDLE, LOAD, STORE_RD, STORE_WR, RESP).
  - funct3 localparams F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
  - functions is_legal(we, funct3) and is_misaligned(funct3, addr[1:0]).
- One combinational sub-module, lsu_lane_align, provides load extract/extend and store merge given word, addr[1:0], funct3 and wdata.

Test Plan:
- Memory word 0x100 = 0x8899AABB; LB at 0x101 -> resp_rdata=0xFFFFFFAA two cycles after accept; LBU at 0x101 -> 0x000000AA.
- Word 0x200 = 0x11223344; SB 0x203 with wdata=0x000000EE -> STORE_RD then STORE_WR with mem_A=0x200, mem_WD=0xEE223344, mem_WE high one cycle; resp_valid 3 cycles after accept.
- SH at 0x202 with wdata 0xCAFE on word 0x00000000 -> mem_WD=0xCAFE0000; a subsequent LH at 0x202 returns 0xFFFFCAFE.
- LW at 0x106 and SH at 0x201 -> resp_err=1, resp_rdata=0 one cycle after accept, mem_WE never high, memory unchanged; load funct3=011 -> resp_err=1.
- Back-to-back requests with req_valid held -> req_ready low from accept until the cycle after RESP, and each request completes in order.
- Assert RST during STORE_WR of an SW -> mem_WE drops in the same cycle, state IDLE, req_ready=1, resp_valid=0, and the target word keeps its old value.
